// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one memory read
// in flight and buffers returned words with their PCs in a small FIFO.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     imem_valid,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state_reg;
    logic [31:0]     fetch_pc_reg;
    logic [31:0]     req_pc_reg;
    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [31:0]     data_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];

    logic            push;
    logic            pop;
    logic            issue;
    logic [CW:0]     post_count;

    // post_count is the occupancy once this cycle's pop and pending write land,
    // so a back-to-back reissue is only made when its response will have a slot.
    always_comb begin
        instr_valid = (count_reg != '0) && !redirect;
        pop         = instr_valid && instr_ready;
        push        = (state_reg == WAIT) && imem_valid && !redirect;
        post_count  = {1'b0, count_reg} + (CW+1)'(1) - (CW+1)'(pop);
        issue       = 1'b0;
        unique case (state_reg)
            IDLE:    issue = !redirect && (count_reg < CW'(DEPTH));
            WAIT:    issue = push && (post_count < (CW+1)'(DEPTH));
            default: issue = 1'b0;
        endcase
        if (rst) begin
            issue = 1'b0;
        end
    end

    assign imem_req   = issue;
    assign imem_addr  = fetch_pc_reg;
    assign instr      = data_mem[rd_ptr_reg];
    assign instr_pc   = pc_mem[rd_ptr_reg];
    assign fill_level = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]   <= req_pc_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= RESET_PC;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else if (redirect) begin
            // Flush; an in-flight read is either retired now or marked for discard.
            fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            unique case (state_reg)
                WAIT:    state_reg <= imem_valid ? IDLE : DROP;
                DROP:    state_reg <= imem_valid ? IDLE : DROP;
                default: state_reg <= IDLE;
            endcase
        end else begin
            if (issue) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
                req_pc_reg   <= fetch_pc_reg;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - CW'(1);
            end
            unique case (state_reg)
                IDLE:    state_reg <= issue ? WAIT : IDLE;
                WAIT:    state_reg <= imem_valid ? (issue ? WAIT : IDLE) : WAIT;
                default: state_reg <= imem_valid ? IDLE : DROP;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and randomized checks of ifetch_queue against a queue-based fetch model
// driven by a variable-latency instruction memory.
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [$clog2(DEPTH):0] fill_level;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: queued {pc, word} pairs, fetch PC, one in-flight read.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_want;
    logic [31:0] m_addr;

    // Instruction memory: responses scheduled by due cycle.
    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;
    rsp_t        memq[$];
    int          lat = 1;
    bit          rand_lat = 1'b0;

    logic [31:0] req_addr[$];
    int          req_cyc[$];
    int          first_valid;
    logic [31:0] first_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        m_pc   = RESET_PC;
        m_busy = 1'b0;
        m_want = 1'b0;
    endfunction

    // One clock cycle: starts 1 time unit after a rising edge.
    task automatic cycle();
        bit   exp_valid;
        bit   exp_pop;
        bit   exp_req;
        rsp_t r;
        ent_t e;
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = memq[0].addr ^ 32'hA5A5_0000;
            void'(memq.pop_front());
        end
        #2;
        exp_valid = (mq.size() != 0) && !redirect;
        exp_pop   = exp_valid && instr_ready;
        if (redirect)                  exp_req = 1'b0;
        else if (!m_busy)              exp_req = mq.size() < DEPTH;
        else if (m_want && imem_valid) exp_req = (mq.size() - int'(exp_pop) + 1) < DEPTH;
        else                           exp_req = 1'b0;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
        chk("fill_level", 32'(fill_level), mq.size());
        if (exp_valid) begin
            chk("instr", instr, mq[0].word);
            chk("instr_pc", instr_pc, mq[0].pc);
        end
        if (instr_valid && first_valid < 0) begin
            first_valid = cyc;
            first_pc    = instr_pc;
        end
        if (imem_req) begin
            r.due  = cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat);
            r.addr = imem_addr;
            memq.push_back(r);
            req_addr.push_back(imem_addr);
            req_cyc.push_back(cyc);
        end
        $display("cyc %0d req=%0b addr=%h rv=%0b redir=%0b rdy=%0b | iv=%0b pc=%h instr=%h fill=%0d",
                 cyc, imem_req, imem_addr, imem_valid, redirect, instr_ready,
                 instr_valid, instr_pc, instr, fill_level);
        if (redirect) begin
            mq.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            if (m_busy && imem_valid) m_busy = 1'b0;
            else                      m_want = 1'b0;
        end else begin
            if (exp_pop) void'(mq.pop_front());
            if (m_busy && imem_valid) begin
                if (m_want) begin
                    e.pc   = m_addr;
                    e.word = m_addr ^ 32'hA5A5_0000;
                    mq.push_back(e);
                end
                m_busy = 1'b0;
            end
            if (exp_req) begin
                m_busy = 1'b1;
                m_want = 1'b1;
                m_addr = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        redirect   = 1'b0;
        imem_valid = 1'b0;
        memq.delete();
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        req_addr.delete();
        req_cyc.delete();
        first_valid = -1;
    endtask

    initial begin
        bit found;
        int n;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        imem_valid = 1'b0; imem_rdata = '0; first_valid = -1; first_pc = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);

        // Streaming with 1-cycle memory
        lat = 1; instr_ready = 1'b1;
        do_reset();
        repeat (8) cycle();
        chk("stream_req0", req_addr[0], 32'h0);
        chk("stream_req1", req_addr[1], 32'h4);
        chk("stream_req2", req_addr[2], 32'h8);
        chk("stream_req2_cyc", req_cyc[2], 32'd2);
        chk("stream_first_valid", first_valid, 32'd2);

        // Stalled decode fills the FIFO
        instr_ready = 1'b0;
        do_reset();
        repeat (10) cycle();
        chk("full_req_count", req_addr.size(), DEPTH);
        chk("full_fill", 32'(fill_level), DEPTH);
        instr_ready = 1'b1;
        repeat (8) cycle();
        chk("resume_addr", req_addr[DEPTH], 32'h10);

        // Redirect while a slow read is in flight
        lat = 3;
        do_reset();
        cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        n = req_addr.size();
        cycle();
        redirect = 1'b0;
        first_valid = -1;
        repeat (12) cycle();
        chk("redir_next_req", req_addr[n], 32'h100);
        chk("redir_first_pc", first_pc, 32'h100);

        // Redirect coinciding with a response and a handshake
        lat = 1;
        do_reset();
        repeat (4) cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        n = req_addr.size();
        cycle();
        redirect = 1'b0;
        chk("redir_hs_fill", 32'(fill_level), 32'd0);
        cycle();
        chk("redir_hs_req", req_addr[n], 32'h200);
        chk("redir_hs_req_cyc", req_cyc[n], cyc - 1);

        // Fetch PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        n = req_addr.size();
        repeat (4) cycle();
        chk("wrap_a", req_addr[n], 32'hFFFF_FFFC);
        chk("wrap_b", req_addr[n+1], 32'h0);

        // Asynchronous reset with a read in flight and two entries queued
        lat = 3; instr_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            found = (mq.size() == 2) && m_busy;
        end
        n_cmp++;
        assert (found) else begin
            n_err++;
            $error("FAIL rst_setup: observed %0d expected 1", found);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_imem_req", 32'(imem_req), 32'd0);
        chk("arst_imem_addr", imem_addr, RESET_PC);
        chk("arst_instr_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_instr_pc", instr_pc, 32'd0);
        chk("arst_fill", 32'(fill_level), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        m_reset();
        req_addr.delete();
        req_cyc.delete();
        first_valid = -1;
        if (memq.size() != 0) memq[0].due = 0;
        lat = 1; instr_ready = 1'b1;
        repeat (6) cycle();
        chk("arst_restart", req_addr[0], RESET_PC);
        chk("arst_first_pc", first_pc, RESET_PC);

        // Randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            cycle();
        end
        redirect = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch front end for the KGP miniRISC core. It sits upstream of the decode/control stage (`cntrlUNIT`/`register_file`) and feeds it. It owns the fetch PC, issues one-outstanding-request reads to instruction memory, and buffers returned words with their PCs in a small FIFO. On a branch/jump redirect it flushes the FIFO and discards any in-flight fetch.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset, word aligned.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: read request to instruction memory, single-cycle pulse per fetch.
- `imem_addr` out 32: byte address of the request; equals the fetch PC.
- `imem_rdata` in 32: returned instruction word.
- `imem_valid` in 1: `imem_rdata` valid; arrives ≥1 cycle after the matching `imem_req`.
- `redirect` in 1: taken branch/jump from the branch/jump control path.
- `redirect_pc` in 32: new fetch PC; bits [1:0] are ignored and treated as 00.
- `instr_valid` out 1: FIFO head is valid.
- `instr` out 32: head instruction word.
- `instr_pc` out 32: byte address of the head instruction.
- `instr_ready` in 1: decode accepts the head this cycle.
- `fill_level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Requires at most one outstanding memory request. FSM states:
  - IDLE: no request in flight.
  - WAIT: one request in flight, response is wanted.
  - DROP: one request in flight, response is to be discarded.
- Issue condition (combinational `imem_req`):
  - In IDLE: `!redirect && count < DEPTH`.
  - In WAIT: `imem_valid && !redirect && (count − pop + 1) < DEPTH`, which gives a back-to-back reissue.
  - Never in DROP.
  - Forced 0 while `rst` is high.
- On issue: `imem_addr` = fetch_pc, fetch_pc += 4 (32-bit wrap), and the next state is WAIT.
- WAIT with `imem_valid`, no redirect:
  - Write {fetch address, `imem_rdata`} to the FIFO tail.
  - Next state is WAIT if reissued, otherwise IDLE.
- Pop: `instr_valid && instr_ready`. Push and pop in the same cycle leave `count` unchanged. A write into an empty FIFO becomes visible at the head the next cycle; there is no bypass.
- `instr_valid` = (count != 0) && !redirect. A handshake in a redirect cycle is void.
- Redirect (highest priority):
  - `count` ← 0 and fetch_pc ← {`redirect_pc`[31:2], 2'b00}.
  - State transition: WAIT without `imem_valid` → DROP. WAIT with `imem_valid` → IDLE, response dropped. IDLE/DROP keep their state, except that DROP with `imem_valid` → IDLE.
  - No request is issued in the redirect cycle. The first request to the new PC goes out the following cycle, once the state is IDLE.
- DROP: on `imem_valid`, discard the data and go to IDLE. A further redirect in DROP only updates fetch_pc.
- Reset (any time, including mid-fetch):
  - State IDLE, count 0, fetch_pc `RESET_PC`.
  - FIFO pointers 0, `fill_level` 0, `instr_valid` 0.
  - `instr`/`instr_pc` read the zeroed head entry (0).
  - A memory response that arrives after reset release with no request issued is ignored, because IDLE ignores `imem_valid`.

## Timing
- Reset outputs: `imem_req` 0, `imem_addr` `RESET_PC`, `instr_valid` 0, `instr` 0, `instr_pc` 0, `fill_level` 0.
- With a 1-cycle memory (`imem_valid` the cycle after `imem_req`):
  - First `imem_req` in cycle 0 after reset release.
  - Data arrives in cycle 1; `instr_valid` goes high in cycle 2.
  - Sustained throughput is 1 instruction/cycle while the FIFO has room.
- Redirect in cycle N:
  - `instr_valid` is 0 in cycle N.
  - Request to the target goes out in N+1, or on the cycle after the pending response if the state is DROP.
  - Target instruction is at the head in N+3 with 1-cycle memory.
- Full: `count == DEPTH` → no issue. The pending response always has a slot because the issue rule counts it in advance.
- `fill_level` is registered and equals `count`.

## Test plan
- Reset release, 1-cycle memory returning word = addr ^ 32'hA5A5_0000, `instr_ready`=1:
  - Requests to 0x0, 0x4, 0x8 on consecutive cycles.
  - `instr`/`instr_pc` pairs match, first `instr_valid` in cycle 2.
- `instr_ready`=0 for 10 cycles with `DEPTH`=4:
  - Exactly 4 requests, then `imem_req` stays 0 and `fill_level`=4.
  - Raising `instr_ready` drains 0x0..0xC in order and fetching resumes at 0x10.
- Redirect to 0x0000_0103 while in WAIT, memory latency 3:
  - FIFO empties and the stale response is discarded.
  - Next request is 0x100, and `instr_pc` 0x100 is the first valid head.
- Redirect coinciding with `imem_valid` and `instr_ready`:
  - No pop, no write, `fill_level`=0.
  - Next request 1 cycle later to the redirect target.
- Fetch PC at 32'hFFFF_FFFC: next request address wraps to 0x0.
- Assert `rst` while in WAIT with 2 entries queued:
  - All outputs return to reset values immediately (asynchronously).
  - A late `imem_valid` after release is ignored, and fetch restarts at `RESET_PC`.
